ins_issue: RTL and testbench

Instruction issue unit that drives the accelerator's instruction input handshake consumed by `top_control`. The host preloads 64-bit instruction words into an internal instruction RAM. A `start` pulse replays a programmed window of that RAM over `ins_valid`/`ins_ready`/`ins`, one word at a time. After the last word is accepted, the block waits for the accelerator's `working` flag to clear and then pulses `done`.

---
 rtl/ins_issue_pkg.sv | 26 ++
 rtl/ins_issue_if.sv | 22 ++
 rtl/ins_ram.sv | 50 +++++
 rtl/ins_issue.sv | 158 +++++++++++++++
 tb/tb_ins_issue.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ins_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ins_issue_pkg
//  Description : Shared instruction constants for the issue unit: the
//                instruction word width and the opcode field layout.
//                The opcode layout is not used inside the issue unit; it is
//                kept here for consumers and test code.
//  Revision    : 1.0 - initial release
// ============================================================================
package ins_issue_pkg;

    // Instruction word width
    localparam int INST_W = 64;

    // Opcode field position within an instruction word
    localparam int OP_HI = 63;
    localparam int OP_LO = 62;

    // Opcode values
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_CALC = 2'b01;
    localparam logic [1:0] OP_SAVE = 2'b10;
    localparam logic [1:0] OP_CONF = 2'b11;

endpackage : ins_issue_pkg
`default_nettype wire

// File: rtl/ins_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : ins_issue_if
//  Description : Instruction handshake bus between the issue unit (master)
//                and the instruction consumer (slave).
//  Signals     : ins_valid - word on ins is valid (master -> slave)
//                ins       - instruction word       (master -> slave)
//                ins_ready - one-cycle accept pulse  (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ins_issue_if;
    import ins_issue_pkg::*;

    logic              ins_valid;
    logic              ins_ready;
    logic [INST_W-1:0] ins;

    modport master (output ins_valid, output ins, input ins_ready);
    modport slave  (input ins_valid, input ins, output ins_ready);

endinterface : ins_issue_if
`default_nettype wire

// File: rtl/ins_ram.sv
`default_nettype none
// ============================================================================
//  Module      : ins_ram
//  Description : Simple dual-port instruction RAM, DEPTH x W. One write
//                port, one synchronous read port. A read and a write to the
//                same address in the same cycle return the old contents.
//                The array is not reset; only the read data register is.
//  Ports       : clk, rst        - clock, async active-high reset
//                wr_en_i/addr/data - write port
//                rd_en_i/rd_addr_i - read request (data next cycle)
//                rd_data_o       - registered read data, held when idle
//  Revision    : 1.0 - initial release
// ============================================================================
module ins_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 64
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          wr_en_i,
    input  wire logic [AW-1:0] wr_addr_i,
    input  wire logic [W-1:0]  wr_data_i,
    input  wire logic          rd_en_i,
    input  wire logic [AW-1:0] rd_addr_i,
    output logic      [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Non-blocking update of the array means a colliding read sees the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : ins_ram
`default_nettype wire

// File: rtl/ins_issue.sv
`default_nettype none
// ============================================================================
//  Module      : ins_issue
//  Description : Instruction issue unit. The host preloads instruction words
//                into an internal RAM; a start pulse replays a window of it
//                over the ins_valid/ins_ready handshake, waits for the
//                accelerator to go idle, then pulses done.
//  Ports       : clk, rst          - clock, async active-high reset
//                host_wr_*_i       - RAM preload write port
//                start_i           - one-cycle run request (IDLE only)
//                ins_base_i        - first RAM address of the window
//                ins_cnt_i         - number of words to issue
//                ins_bus           - instruction handshake (master side)
//                working_i         - accelerator busy flag
//                busy_o            - run in progress
//                done_o            - one-cycle completion pulse
//                issued_o          - words accepted in the current run
//  Revision    : 1.0 - initial release
// ============================================================================
module ins_issue
    import ins_issue_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int AW        = $clog2(DEPTH),
    parameter int DRAIN_CYC = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              host_wr_en_i,
    input  wire logic [AW-1:0]     host_wr_addr_i,
    input  wire logic [INST_W-1:0] host_wr_data_i,
    input  wire logic              start_i,
    input  wire logic [AW-1:0]     ins_base_i,
    input  wire logic [AW:0]       ins_cnt_i,
    ins_issue_if.master            ins_bus,
    input  wire logic              working_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic      [AW:0]       issued_o
);

    localparam int DW = $clog2(DRAIN_CYC);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_FETCH     = 3'd1;
    localparam logic [2:0] c_ISSUE     = 3'd2;
    localparam logic [2:0] c_DRAIN     = 3'd3;
    localparam logic [2:0] c_WAIT_IDLE = 3'd4;
    localparam logic [2:0] c_DONE      = 3'd5;

    localparam logic [AW-1:0] c_ONE_PTR    = AW'(1);
    localparam logic [AW:0]   c_ONE_CNT    = (AW+1)'(1);
    localparam logic [DW-1:0] c_ONE_DRAIN  = DW'(1);
    localparam logic [DW-1:0] c_DRAIN_LAST = DW'(DRAIN_CYC - 1);

    logic [2:0]        state_q,  state_d;
    logic [AW-1:0]     ptr_q,    ptr_d;
    logic [AW:0]       remain_q, remain_d;
    logic [AW:0]       issued_q, issued_d;
    logic [DW-1:0]     drain_q,  drain_d;
    logic              done_q;
    logic              w_rd_en;
    logic [INST_W-1:0] w_rd_data;

    ins_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (INST_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (host_wr_en_i),
        .wr_addr_i (host_wr_addr_i),
        .wr_data_i (host_wr_data_i),
        .rd_en_i   (w_rd_en),
        .rd_addr_i (ptr_q),
        .rd_data_o (w_rd_data)
    );

    // The read register only loads in FETCH, so ins stays stable through ISSUE.
    assign w_rd_en = (state_q == c_FETCH);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        remain_d = remain_q;
        issued_d = issued_q;
        drain_d  = drain_q;
        case (state_q)
            c_IDLE: begin
                if (start_i) begin
                    ptr_d    = ins_base_i;
                    remain_d = ins_cnt_i;
                    issued_d = '0;
                    state_d  = (ins_cnt_i != '0) ? c_FETCH : c_DONE;
                end
            end
            c_FETCH: begin
                state_d = c_ISSUE;
            end
            c_ISSUE: begin
                if (ins_bus.ins_ready) begin
                    ptr_d    = ptr_q + c_ONE_PTR;       // wraps modulo DEPTH
                    remain_d = remain_q - c_ONE_CNT;
                    issued_d = issued_q + c_ONE_CNT;
                    drain_d  = '0;
                    state_d  = (remain_q > c_ONE_CNT) ? c_FETCH : c_DRAIN;
                end
            end
            c_DRAIN: begin
                // Covers the consumer's registered ready/done feedback lag
                if (drain_q == c_DRAIN_LAST) begin
                    state_d = c_WAIT_IDLE;
                end else begin
                    drain_d = drain_q + c_ONE_DRAIN;
                end
            end
            c_WAIT_IDLE: begin
                if (!working_i) begin
                    state_d = c_DONE;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= c_IDLE;
            ptr_q    <= '0;
            remain_q <= '0;
            issued_q <= '0;
            drain_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            remain_q <= remain_d;
            issued_q <= issued_d;
            drain_q  <= drain_d;
            // Registered so done is glitch-free; it follows the DONE state by one cycle.
            done_q   <= (state_q == c_DONE);
        end
    end

    assign ins_bus.ins_valid = (state_q == c_ISSUE);
    assign ins_bus.ins       = w_rd_data;
    assign busy_o            = (state_q != c_IDLE);
    assign done_o            = done_q;
    assign issued_o          = issued_q;

endmodule : ins_issue
`default_nettype wire

// File: tb/tb_ins_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ins_issue
//  Description : Directed self-checking bench for ins_issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ins_issue;
    import ins_issue_pkg::*;

    localparam int DEPTH     = 1024;
    localparam int AW        = 10;
    localparam int DRAIN_CYC = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              host_wr_en;
    logic [AW-1:0]     host_wr_addr;
    logic [INST_W-1:0] host_wr_data;
    logic              start;
    logic [AW-1:0]     ins_base;
    logic [AW:0]       ins_cnt;
    logic              working;
    logic              busy;
    logic              done;
    logic [AW:0]       issued;

    int n_assert = 0;
    int n_fail   = 0;

    ins_issue_if bus ();

    ins_issue #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_wr_en_i   (host_wr_en),
        .host_wr_addr_i (host_wr_addr),
        .host_wr_data_i (host_wr_data),
        .start_i        (start),
        .ins_base_i     (ins_base),
        .ins_cnt_i      (ins_cnt),
        .ins_bus        (bus),
        .working_i      (working),
        .busy_o         (busy),
        .done_o         (done),
        .issued_o       (issued)
    );

    always #5 clk = ~clk;

    logic [63:0] w  [4] = '{64'h0000_0000_0000_0011, 64'h4000_0000_0000_0022,
                            64'h8000_0000_0000_0033, 64'hC000_0000_0000_0044};
    logic [63:0] wr [4] = '{64'h1234_5678_0000_0A0A, 64'h5234_5678_0000_0B0B,
                            64'h9234_5678_0000_0C0C, 64'hD234_5678_0000_0D0D};
    logic [1:0]  ops[4] = '{OP_LOAD, OP_CALC, OP_SAVE, OP_CONF};
    logic [63:0] captured [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [63:0] d);
        host_wr_en   = 1'b1;
        host_wr_addr = a;
        host_wr_data = d;
        tick();
        host_wr_en   = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] cnt);
        ins_base = base;
        ins_cnt  = cnt;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!bus.ins_valid && n < 10) begin
            tick();
            n++;
        end
        chk(tag, 64'(bus.ins_valid), 64'd1);
    endtask

    // Waits for a valid word, holds ready low for dly cycles, then accepts it.
    task automatic accept(input string tag, input logic [63:0] exp, input int dly,
                          output logic [63:0] got, output int nwait);
        wait_valid({tag, "_valid"}, nwait);
        chk({tag, "_ins"}, bus.ins, exp);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk({tag, "_hold"}, bus.ins, exp);
        end
        bus.ins_ready = 1'b1;
        got = bus.ins;
        tick();
        bus.ins_ready = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    initial begin
        int          n;
        int          early;
        logic [63:0] got;

        rst          = 1'b1;
        host_wr_en   = 1'b0;
        host_wr_addr = '0;
        host_wr_data = '0;
        start        = 1'b0;
        ins_base     = '0;
        ins_cnt      = '0;
        working      = 1'b0;
        bus.ins_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_valid",  64'(bus.ins_valid), 64'd0);
        chk("rst_ins",    bus.ins,            64'd0);
        chk("rst_busy",   64'(busy),          64'd0);
        chk("rst_done",   64'(done),          64'd0);
        chk("rst_issued", 64'(issued),        64'd0);
        rst = 1'b0;
        tick();

        // Basic run: 4 words, ready 3 cycles after each valid
        for (int k = 0; k < 4; k++) host_write(AW'(k), w[k]);
        do_start(10'd0, 11'd4);
        chk("basic_fetch_busy",  64'(busy),          64'd1);
        chk("basic_fetch_valid", 64'(bus.ins_valid), 64'd0);
        tick();
        chk("basic_first_valid", 64'(bus.ins_valid), 64'd1);
        for (int k = 0; k < 4; k++) begin
            accept("basic", w[k], 3, got, n);
            captured[k] = got;
            chk("basic_issued", 64'(issued), 64'(k + 1));
        end
        for (int k = 0; k < 4; k++) begin
            got = captured[k];
            chk("basic_opcode", 64'(got[OP_HI:OP_LO]), 64'(ops[k]));
        end
        // Last handshake -> DRAIN_CYC drain cycles -> WAIT_IDLE -> DONE -> done
        wait_done("basic_done", n);
        chk("basic_done_lat", 64'(n),      64'(DRAIN_CYC + 2));
        chk("basic_issued_f", 64'(issued), 64'd4);
        chk("basic_busy_f",   64'(busy),   64'd0);
        tick();
        chk("basic_done_pulse", 64'(done), 64'd0);

        // Zero count: done two cycles after start, never valid
        do_start(10'd5, 11'd0);
        chk("zero_done_t1",  64'(done),          64'd0);
        chk("zero_valid_t1", 64'(bus.ins_valid), 64'd0);
        chk("zero_busy_t1",  64'(busy),          64'd1);
        tick();
        chk("zero_done_t2",  64'(done),          64'd1);
        chk("zero_valid_t2", 64'(bus.ins_valid), 64'd0);
        chk("zero_issued",   64'(issued),        64'd0);
        tick();
        chk("zero_done_t3",  64'(done),          64'd0);

        // Wrap: window 1022, 1023, 0, 1 at peak rate
        host_write(10'd1022, wr[0]);
        host_write(10'd1023, wr[1]);
        host_write(10'd0,    wr[2]);
        host_write(10'd1,    wr[3]);
        do_start(10'd1022, 11'd4);
        for (int k = 0; k < 4; k++) begin
            accept("wrap", wr[k], 0, got, n);
            if (k > 0) chk("wrap_rate", 64'(n), 64'd1);
        end
        wait_done("wrap_done", n);
        chk("wrap_issued", 64'(issued), 64'd4);

        // Working hold: done only after working falls
        working = 1'b1;
        do_start(10'd2, 11'd1);
        accept("hold", w[2], 1, got, n);
        early = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) early++;
        end
        chk("hold_no_early_done", 64'(early), 64'd0);
        chk("hold_busy",          64'(busy),  64'd1);
        working = 1'b0;
        wait_done("hold_done", n);
        chk("hold_done_lat", 64'(n),      64'd2);
        chk("hold_issued",   64'(issued), 64'd1);

        // Spurious ready in IDLE and FETCH, back-pressure, start during ISSUE
        bus.ins_ready = 1'b1;
        tick();
        chk("idle_ready_issued", 64'(issued),        64'd1);
        chk("idle_ready_valid",  64'(bus.ins_valid), 64'd0);
        bus.ins_ready = 1'b0;
        do_start(10'd2, 11'd2);
        bus.ins_ready = 1'b1;
        tick();
        bus.ins_ready = 1'b0;
        chk("fetch_ready_issued", 64'(issued),        64'd0);
        chk("fetch_ready_valid",  64'(bus.ins_valid), 64'd1);
        chk("fetch_ready_ins",    bus.ins,            w[2]);
        early = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                ins_base = 10'd3;
                ins_cnt  = 11'd1;
                start    = 1'b1;
            end
            tick();
            start = 1'b0;
            if (bus.ins !== w[2] || !bus.ins_valid) early++;
        end
        chk("bp_ins_stable", 64'(early),  64'd0);
        chk("bp_issued",     64'(issued), 64'd0);
        accept("bp0", w[2], 0, got, n);
        accept("bp1", w[3], 0, got, n);
        wait_done("bp_done", n);
        chk("bp_issued_f", 64'(issued), 64'd2);

        // Async reset during the second ISSUE
        do_start(10'd2, 11'd3);
        accept("rst0", w[2], 0, got, n);
        wait_valid("rst_second_issue", n);
        rst = 1'b1;
        #1;
        chk("arst_valid",  64'(bus.ins_valid), 64'd0);
        chk("arst_busy",   64'(busy),          64'd0);
        chk("arst_ins",    bus.ins,            64'd0);
        chk("arst_issued", 64'(issued),        64'd0);
        tick();
        tick();
        rst = 1'b0;
        early = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) early++;
        end
        chk("arst_no_done", 64'(early), 64'd0);
        do_start(10'd1022, 11'd2);
        accept("post_rst0", wr[0], 2, got, n);
        accept("post_rst1", wr[1], 2, got, n);
        wait_done("post_rst_done", n);
        chk("post_rst_issued", 64'(issued), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_ins_issue
`default_nettype wire
